// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle DMA streamer: record layout constants,
// flag bit positions, FSM state encoding and cursor field select.
package rect_pkg;

  localparam int RECORD_WORDS = 6;
  localparam int FLAG_ABS     = 0;
  localparam int FLAG_HIDDEN  = 1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PRIME = 4'd1,
    ST_FLAGS = 4'd2,
    ST_X     = 4'd3,
    ST_Y     = 4'd4,
    ST_W     = 4'd5,
    ST_H     = 4'd6,
    ST_COLOR = 4'd7,
    ST_DONE  = 4'd8
  } state_e;

  typedef enum logic {
    SEL_X = 1'b0,
    SEL_Y = 1'b1
  } coord_sel_e;

endpackage

// File: rtl/coord_resolver.sv
// Owns the running x/y cursor and resolves a record coordinate as either an
// absolute value (which also moves the cursor) or an offset from the cursor.
module coord_resolver
  import rect_pkg::*;
#(
  parameter int COORD_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  coord_sel_e             field_sel,
  input  logic                   abs_flag,
  input  logic [COORD_WIDTH-1:0] value,
  output logic [COORD_WIDTH-1:0] coord
);

  logic [COORD_WIDTH-1:0] cursor_x_r;
  logic [COORD_WIDTH-1:0] cursor_y_r;
  logic [COORD_WIDTH-1:0] cursor_s;

  // Resolve against the selected cursor; relative sums wrap modulo 2^COORD_WIDTH.
  always_comb begin
    cursor_s = cursor_x_r;
    if (field_sel == SEL_Y) begin
      cursor_s = cursor_y_r;
    end else begin
      cursor_s = cursor_x_r;
    end
    if (abs_flag) begin
      coord = value;
    end else begin
      coord = cursor_s + value;
    end
  end

  // Only absolute coordinates move the cursor; it survives across frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_x_r <= {COORD_WIDTH{1'b0}};
      cursor_y_r <= {COORD_WIDTH{1'b0}};
    end else if (enable && abs_flag) begin
      if (field_sel == SEL_Y) begin
        cursor_y_r <= value;
      end else begin
        cursor_x_r <= value;
      end
    end
  end

endmodule

// File: rtl/rect_dma_streamer.sv
// Streams RECT_COUNT six-word rectangle records from data memory to the GPU
// loader, resolving coordinates and blanking the size of hidden records.
module rect_dma_streamer
  import rect_pkg::*;
#(
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int RECT_COUNT  = 64,
  parameter int REC_WORDS   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_din,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(RECT_COUNT + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(RECT_COUNT - 32'd1);
  localparam logic [IDX_W-1:0]      IDX_STEP  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  if (REC_WORDS != RECORD_WORDS || COORD_WIDTH > 16 || RECT_COUNT < 1) begin : g_param_check
    $error("rect_dma_streamer: unsupported parameter set");
  end

  state_e                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_s;
  logic [IDX_W-1:0]        rect_idx_r, rect_idx_s;
  logic                    abs_r, abs_s;
  logic                    hid_r, hid_s;
  logic                    out_valid_r, out_valid_s;
  logic [15:0]             out_data_r, out_data_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  coord_sel_e              field_sel_s;
  logic                    coord_en_s;
  logic [COORD_WIDTH-1:0]  coord_s;

  assign field_sel_s = (state_r == ST_Y) ? SEL_Y : SEL_X;
  assign coord_en_s  = (state_r == ST_X) || (state_r == ST_Y);

  coord_resolver #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_coord (
    .clk       (clk),
    .reset     (reset),
    .enable    (coord_en_s),
    .field_sel (field_sel_s),
    .abs_flag  (abs_r),
    .value     (mem_din[COORD_WIDTH-1:0]),
    .coord     (coord_s)
  );

  // Next-state and next-output logic; every output word is registered one cycle later.
  always_comb begin
    state_s     = state_r;
    mem_addr_s  = mem_addr_r;
    rect_idx_s  = rect_idx_r;
    abs_s       = abs_r;
    hid_s       = hid_r;
    out_valid_s = 1'b0;
    out_data_s  = 16'h0000;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mem_addr_s = base_addr;
          busy_s     = 1'b1;
          state_s    = ST_PRIME;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_PRIME: begin
        mem_addr_s = mem_addr_r + ADDR_STEP;
        state_s    = ST_FLAGS;
      end
      ST_FLAGS: begin
        abs_s       = mem_din[FLAG_ABS];
        hid_s       = mem_din[FLAG_HIDDEN];
        out_valid_s = 1'b1;
        out_data_s  = 16'h0000;
        mem_addr_s  = mem_addr_r + ADDR_STEP;
        state_s     = ST_X;
      end
      ST_X, ST_Y: begin
        out_valid_s = 1'b1;
        out_data_s  = abs_r ? mem_din : 16'(coord_s);
        mem_addr_s  = mem_addr_r + ADDR_STEP;
        state_s     = (state_r == ST_X) ? ST_Y : ST_W;
      end
      ST_W, ST_H: begin
        out_valid_s = 1'b1;
        out_data_s  = hid_r ? 16'h0000 : 16'(mem_din[COORD_WIDTH-1:0]);
        mem_addr_s  = mem_addr_r + ADDR_STEP;
        state_s     = (state_r == ST_W) ? ST_H : ST_COLOR;
      end
      ST_COLOR: begin
        out_valid_s = 1'b1;
        out_data_s  = mem_din;
        mem_addr_s  = mem_addr_r + ADDR_STEP;
        if (rect_idx_r == LAST_IDX) begin
          state_s    = ST_DONE;
        end else begin
          rect_idx_s = rect_idx_r + IDX_STEP;
          state_s    = ST_FLAGS;
        end
      end
      ST_DONE: begin
        done_s     = 1'b1;
        busy_s     = 1'b0;
        rect_idx_s = {IDX_W{1'b0}};
        state_s    = ST_IDLE;
      end
      default: begin
        busy_s     = 1'b0;
        rect_idx_s = {IDX_W{1'b0}};
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      rect_idx_r  <= {IDX_W{1'b0}};
      abs_r       <= 1'b0;
      hid_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_addr_r  <= mem_addr_s;
      rect_idx_r  <= rect_idx_s;
      abs_r       <= abs_s;
      hid_r       <= hid_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_rect_dma_streamer.sv
// Directed plus randomized checks of rect_dma_streamer against a per-record
// reference model; two instances cover RECT_COUNT=2 and RECT_COUNT=1.
module tb_rect_dma_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  bit          sel;

  logic        start2, start1;
  logic [15:0] mem_addr2, mem_addr1, mem_din2, mem_din1;
  logic [15:0] out_data2, out_data1;
  logic        out_valid2, out_valid1, busy2, busy1, done2, done1;

  logic        o_valid, o_busy, o_done;
  logic [15:0] o_data, o_addr;

  logic [15:0] mem [0:65535];
  logic [15:0] m_cx [2];
  logic [15:0] m_cy [2];
  logic [15:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign start2 = start & ~sel;
  assign start1 = start & sel;

  assign o_valid = sel ? out_valid1 : out_valid2;
  assign o_data  = sel ? out_data1  : out_data2;
  assign o_busy  = sel ? busy1      : busy2;
  assign o_done  = sel ? done1      : done2;
  assign o_addr  = sel ? mem_addr1  : mem_addr2;

  always @(posedge clk) begin
    mem_din2 <= mem[mem_addr2];
    mem_din1 <= mem[mem_addr1];
  end

  rect_dma_streamer #(.COORD_WIDTH(16), .ADDR_WIDTH(16), .RECT_COUNT(2), .REC_WORDS(6)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr),
    .mem_addr(mem_addr2), .mem_din(mem_din2), .out_valid(out_valid2),
    .out_data(out_data2), .busy(busy2), .done(done2)
  );

  rect_dma_streamer #(.COORD_WIDTH(16), .ADDR_WIDTH(16), .RECT_COUNT(1), .REC_WORDS(6)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .base_addr(base_addr),
    .mem_addr(mem_addr1), .mem_din(mem_din1), .out_valid(out_valid1),
    .out_data(out_data1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic write_rec(input logic [15:0] a, input logic [15:0] f, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] c);
    mem[a]         = f;
    mem[a + 16'd1] = x;
    mem[a + 16'd2] = y;
    mem[a + 16'd3] = w;
    mem[a + 16'd4] = h;
    mem[a + 16'd5] = c;
  endtask

  // Expected packet stream for n records at base, advancing the model cursor.
  function automatic void build_expected(input logic [15:0] base, input int n, input int which);
    logic [15:0] a, f, x, y;
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      a = base + 16'(6 * r);
      f = mem[a];
      x = mem[a + 16'd1];
      y = mem[a + 16'd2];
      exp_q.push_back(16'h0000);
      if (f[0]) begin
        m_cx[which] = x;
        m_cy[which] = y;
        exp_q.push_back(x);
        exp_q.push_back(y);
      end else begin
        exp_q.push_back(m_cx[which] + x);
        exp_q.push_back(m_cy[which] + y);
      end
      exp_q.push_back(f[1] ? 16'h0000 : mem[a + 16'd3]);
      exp_q.push_back(f[1] ? 16'h0000 : mem[a + 16'd4]);
      exp_q.push_back(mem[a + 16'd5]);
    end
  endfunction

  task automatic idle_check(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk("idle_valid", o_valid, 16'd0);
      chk("idle_busy", o_busy, 16'd0);
      chk("idle_done", o_done, 16'd0);
      chk("idle_data", o_data, 16'h0000);
    end
  endtask

  // Starts one frame on the selected instance and checks every cycle through done.
  task automatic run_frame(input logic [15:0] base, input bit hold);
    int n;
    bit ev;
    n = sel ? 1 : 2;
    build_expected(base, n, sel ? 1 : 0);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    base_addr = 16'($urandom);
    for (int k = 0; k <= 6 * n + 2; k++) begin
      if (k > 0) @(negedge clk);
      ev = (k >= 2) && (k <= 6 * n + 1);
      chk("valid", o_valid, {15'd0, ev});
      chk("data", o_data, ev ? exp_q[k - 2] : 16'h0000);
      chk("busy", o_busy, {15'd0, (k <= 6 * n + 1)});
      chk("done", o_done, {15'd0, (k == 6 * n + 2)});
      if (k <= 6 * n) chk("addr", o_addr, base + 16'(k));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    m_cx[0] = 16'h0000; m_cy[0] = 16'h0000;
    m_cx[1] = 16'h0000; m_cy[1] = 16'h0000;
    sel = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = 16'h0000;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      chk("rst_valid", o_valid, 16'd0);
      chk("rst_data", o_data, 16'h0000);
      chk("rst_busy", o_busy, 16'd0);
      chk("rst_done", o_done, 16'd0);
      chk("rst_addr", o_addr, 16'h0000);
    end
    sel = 1'b0;
    reset = 1'b0;
    idle_check(3);

    // Hidden relative record from a zero cursor, then a relative one proving the cursor held.
    write_rec(16'h0200, 16'd2, 16'd3, 16'd4, 16'd50, 16'd60, 16'h0ABC);
    write_rec(16'h0206, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'h0123);
    run_frame(16'h0200, 1'b0);

    write_rec(16'h0100, 16'd1, 16'd10, 16'd20, 16'd30, 16'd40, 16'h0F00);
    write_rec(16'h0106, 16'd0, 16'd5, 16'd6, 16'd7, 16'd8, 16'h00F0);
    run_frame(16'h0100, 1'b0);

    write_rec(16'h0400, 16'd1, 16'hFFFE, 16'd5, 16'd1, 16'd1, 16'd1);
    write_rec(16'h0406, 16'd0, 16'd3, 16'hFFFF, 16'd9, 16'd9, 16'd2);
    run_frame(16'h0400, 1'b0);

    // Start held through a frame, then re-accepted the cycle after done.
    write_rec(16'h0500, 16'hFFF8, 16'd7, 16'd9, 16'd11, 16'd13, 16'h5555);
    write_rec(16'h0506, 16'd2, 16'd100, 16'd200, 16'd1, 16'd1, 16'hAAAA);
    run_frame(16'h0500, 1'b1);
    run_frame(16'h0500, 1'b0);
    idle_check(4);

    repeat (6) begin
      logic [15:0] b;
      b = 16'($urandom);
      for (int r = 0; r < 2; r++)
        write_rec(b + 16'(6 * r), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom));
      run_frame(b, 1'b0);
      idle_check($urandom_range(0, 3));
    end

    // Single-record instance at the top of the address space.
    sel = 1'b1;
    write_rec(16'hFFFA, 16'd0, 16'd21, 16'd22, 16'd23, 16'd24, 16'h0C0C);
    mem[0] = 16'hDEAD;
    run_frame(16'hFFFA, 1'b0);
    idle_check(2);
    sel = 1'b0;

    // Reset on the third output word aborts the frame.
    write_rec(16'h0300, 16'd1, 16'd40, 16'd41, 16'd5, 16'd5, 16'd1);
    write_rec(16'h0306, 16'd0, 16'd1, 16'd1, 16'd5, 16'd5, 16'd1);
    base_addr = 16'h0300;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_third_valid", o_valid, 16'd1);
    chk("t5_third_data", o_data, 16'd41);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_valid", o_valid, 16'd0);
    chk("t5_busy", o_busy, 16'd0);
    chk("t5_addr", o_addr, 16'h0000);
    chk("t5_done", o_done, 16'd0);
    chk("t5_data", o_data, 16'h0000);
    reset = 1'b0;
    m_cx[0] = 16'h0000; m_cy[0] = 16'h0000;
    m_cx[1] = 16'h0000; m_cy[1] = 16'h0000;
    idle_check(15);

    // Relative records after reset resolve against a cleared cursor.
    write_rec(16'h0600, 16'd0, 16'd7, 16'd8, 16'd1, 16'd2, 16'h0777);
    write_rec(16'h0606, 16'd0, 16'd1, 16'd1, 16'd3, 16'd4, 16'h0888);
    run_frame(16'h0600, 1'b0);
    idle_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
